relogio_multimodo: RTL and testbench
====================================

Name: relogio_multimodo

Overview:
Parametrised successor of the single-mode display clock. Keeps an HH:MM:SS value with per-field adjustment from four push-buttons and runs in one of two modes: a wrapping time-of-day counter (up) or a countdown timer (down) that raises an alarm at zero. Drives a multiplexed, active-low 7-segment bank of N_AN digits. It sits at board top level between the debounced button inputs and the display pins.

Parameters:
TICK_DIV, 100_000_000, clock cycles per 1 s count tick
SCAN_DIV, 100_000, clock cycles each digit is lit
DEB_CYC, 4, cycles a synchronised button must stay stable before it is accepted; board builds override this
N_AN, 8, anode count; must be at least 6
HORAS_MAX, 24, hour field modulus (1..99)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
start  in  1  run/stop button
cont  in  1  edit-field / acknowledge button
soma  in  1  increment button
subtracao  in  1  decrement button
modo  in  1  0 = count up (clock), 1 = count down (timer)
an  out  N_AN  anode enables, active-low
dec_cat  out  8  segments {dp,g,f,e,d,c,b,a}, active-low
alarme  out  1  high while in FIM
segundo  out  1  one-cycle pulse on each count tick while RODANDO

Behaviour:
- Reset: one clock, reset synchronous, active-high (already decided). Next edge sets state PARADO, time 00:00:00, alarme=0, segundo=0, scan index 0, prescalers 0, an = all 1 except an[0]=0, dec_cat=8'hC0.
- Buttons: 2-FF synchroniser, then DEB_CYC stability filter, then rising-edge detect. Result is a one-cycle "accepted" pulse, 2+DEB_CYC+1 cycles after the pin rises. Holding a button produces one pulse only.
- Time is stored as six BCD digits (Hh, Hu, Mt, Mu, St, Su). No dividers.
- FSM states:
  - PARADO: start -> RODANDO; cont -> AJUSTE_H. Exception: start with modo=1 and time 00:00:00 is ignored.
  - RODANDO: on each tick, modo=0 adds 1 s, wrapping (HORAS_MAX-1):59:59 -> 00:00:00. modo=1 subtracts 1 s with borrow (01:00:00 -> 00:59:59). Reaching 00:00:00 in modo=1 -> FIM on the same edge. start -> PARADO. cont, soma and subtracao are ignored.
  - AJUSTE_H / AJUSTE_M / AJUSTE_S: soma = field+1, subtracao = field-1, both modulo the field limit (HORAS_MAX or 60) with wrap in both directions. cont advances H -> M -> S -> PARADO. start is ignored.
  - FIM: alarme=1, time held at 00:00:00. start or cont -> PARADO.
- Tick prescaler: cleared on entry to RODANDO. The first tick comes TICK_DIV cycles after the accepted start pulse; ticks then repeat every TICK_DIV cycles.
- Changing modo during RODANDO takes effect at the next tick.
- Simultaneous soma and subtracao pulses in the same cycle: no change.
- Simultaneous start and cont pulses in PARADO: start wins.
- Reset mid-operation aborts everything; reset state applies on the next edge.
- Display scan:
  - Index 0..5 advances every SCAN_DIV cycles and wraps 5 -> 0.
  - an[i]=0 only for the current index; an[N_AN-1:6] is always 1.
  - Digit map: 0=Su, 1=St, 2=Mu, 3=Mt, 4=Hu, 5=Hh.
- Segment output:
  - dec_cat is the registered decode of the selected digit and changes on the same edge as an.
  - dp is lit on digits 2 and 4 (separators).
  - In AJUSTE_x, dp is additionally lit on both digits of the field being edited.
- Segment codes, active-low {dp off}: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.

Decomposition:
- Package relogio_pkg:
  - state enum (PARADO, RODANDO, AJUSTE_H, AJUSTE_M, AJUSTE_S, FIM)
  - segment LUT constants and the BCD-to-segment function
  - digit index constants
  - field limit 59
- Sub-module botao_sync: synchroniser, DEB_CYC filter and edge detect, parameter DEB_CYC. Instantiated four times.
- Top module holds the FSM, BCD time registers, tick prescaler and scan logic.

Test Plan (TICK_DIV=10, SCAN_DIV=4, DEB_CYC=2):
1. Reset held 5 cycles then released -> an=8'hFE, dec_cat=8'hC0, alarme=0; scan gives an = FE,FD,FB,F7,EF,DF at 4 cycles each, an[7:6] always 1, dec_cat=C0 on digits 0,1,3,5 and 40 on digits 2,4.
2. cont; subtracao; cont; soma x3; cont; cont -> hours 23, minutes 03; final state PARADO; digits read 23:03:00.
3. Set 23:59:59, modo=0, start -> segundo pulses 10 cycles after the accepted start pulse, time becomes 00:00:00.
4. Set 00:00:02, modo=1, start -> 00:00:01 after 10 cycles; 00:00:00 and alarme=1 after 20 cycles; cont -> alarme=0, PARADO.
5. In AJUSTE_M at minutes 00: soma and subtracao asserted together -> 00 unchanged; subtracao alone -> 59; start pressed -> still AJUSTE_M.
6. Reset asserted mid-RODANDO at 00:00:07 -> next edge time 00:00:00, PARADO, segundo=0; modo=1 with start -> stays PARADO.

Source files
------------

// File: rtl/relogio_pkg.sv
// Shared types and helpers for the multimode display clock: FSM states,
// 7-segment codes, digit positions and BCD field arithmetic.
package relogio_pkg;

    typedef enum logic [2:0] {
        PARADO,
        RODANDO,
        AJUSTE_H,
        AJUSTE_M,
        AJUSTE_S,
        FIM
    } estado_t;

    localparam logic [7:0] SEG_0 = 8'hC0;
    localparam logic [7:0] SEG_1 = 8'hF9;
    localparam logic [7:0] SEG_2 = 8'hA4;
    localparam logic [7:0] SEG_3 = 8'hB0;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_5 = 8'h92;
    localparam logic [7:0] SEG_6 = 8'h82;
    localparam logic [7:0] SEG_7 = 8'hF8;
    localparam logic [7:0] SEG_8 = 8'h80;
    localparam logic [7:0] SEG_9 = 8'h90;
    localparam logic [7:0] SEG_APAGADO = 8'hFF;

    localparam logic [2:0] DIG_SU = 3'd0;
    localparam logic [2:0] DIG_ST = 3'd1;
    localparam logic [2:0] DIG_MU = 3'd2;
    localparam logic [2:0] DIG_MT = 3'd3;
    localparam logic [2:0] DIG_HU = 3'd4;
    localparam logic [2:0] DIG_HH = 3'd5;

    // Largest value of the minutes and seconds fields, in BCD
    localparam logic [7:0] LIMITE_MS = 8'h59;

    function automatic logic [7:0] bcd_para_seg(input logic [3:0] d);
        case (d)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_APAGADO;
        endcase
    endfunction

    // Two-digit BCD field {tens, units}, wrapping between 00 and maximo
    function automatic logic [7:0] campo_inc(input logic [7:0] v, input logic [7:0] maximo);
        if (v == maximo)
            return 8'h00;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] campo_dec(input logic [7:0] v, input logic [7:0] maximo);
        if (v == 8'h00)
            return maximo;
        else if (v[3:0] == 4'd0)
            return {v[7:4] - 4'd1, 4'd9};
        else
            return {v[7:4], v[3:0] - 4'd1};
    endfunction

endpackage

// File: rtl/botao_sync.sv
// Button conditioner: two-flop synchroniser, stability filter and rising-edge
// detector producing one registered pulse per accepted press.
module botao_sync #(
    parameter int unsigned DEB_CYC = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic botao,
    output logic pulso
);

    localparam int CNT_W = $clog2(DEB_CYC + 1);

    logic             s1;
    logic             s2;
    logic             estavel;
    logic             estavel_ant;
    logic [CNT_W-1:0] cnt;

    // The filtered level only follows s2 after DEB_CYC consecutive differing samples
    always_ff @(posedge clock) begin
        if (reset) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            estavel     <= 1'b0;
            estavel_ant <= 1'b0;
            cnt         <= '0;
            pulso       <= 1'b0;
        end else begin
            s1          <= botao;
            s2          <= s1;
            estavel_ant <= estavel;
            pulso       <= estavel & ~estavel_ant;
            if (s2 != estavel) begin
                if (cnt == CNT_W'(DEB_CYC - 1)) begin
                    estavel <= s2;
                    cnt     <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/relogio_multimodo.sv
// HH:MM:SS clock / countdown timer with button adjustment and a multiplexed
// active-low 7-segment display.
module relogio_multimodo #(
    parameter int unsigned TICK_DIV  = 100_000_000,
    parameter int unsigned SCAN_DIV  = 100_000,
    parameter int unsigned DEB_CYC   = 4,
    parameter int unsigned N_AN      = 8,
    parameter int unsigned HORAS_MAX = 24
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic            cont,
    input  logic            soma,
    input  logic            subtracao,
    input  logic            modo,
    output logic [N_AN-1:0] an,
    output logic [7:0]      dec_cat,
    output logic            alarme,
    output logic            segundo
);

    import relogio_pkg::*;

    localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [7:0] HORA_MAX = {4'((HORAS_MAX - 1) / 10), 4'((HORAS_MAX - 1) % 10)};

    logic p_start, p_cont, p_soma, p_sub;

    botao_sync #(.DEB_CYC(DEB_CYC)) u_start (.clock(clock), .reset(reset), .botao(start),     .pulso(p_start));
    botao_sync #(.DEB_CYC(DEB_CYC)) u_cont  (.clock(clock), .reset(reset), .botao(cont),      .pulso(p_cont));
    botao_sync #(.DEB_CYC(DEB_CYC)) u_soma  (.clock(clock), .reset(reset), .botao(soma),      .pulso(p_soma));
    botao_sync #(.DEB_CYC(DEB_CYC)) u_sub   (.clock(clock), .reset(reset), .botao(subtracao), .pulso(p_sub));

    estado_t           estado, estado_prox;
    logic [23:0]       tempo, tempo_prox;
    logic [PRE_W-1:0]  pre_tick;
    logic [SCAN_W-1:0] pre_scan;
    logic [2:0]        idx, idx_prox;
    logic              tick, scan_passo, ajusta_mais, ajusta_menos, ponto;
    logic [3:0]        digito;
    logic [N_AN-1:0]   an_prox;
    logic [7:0]        cat_prox;

    assign tick         = (estado == RODANDO) && (pre_tick == PRE_W'(TICK_DIV - 1));
    assign ajusta_mais  = p_soma & ~p_sub;
    assign ajusta_menos = p_sub & ~p_soma;
    assign alarme       = (estado == FIM);

    // tempo = {Hh, Hu, Mt, Mu, St, Su}, one BCD digit per nibble
    always_comb begin
        estado_prox = estado;
        tempo_prox  = tempo;
        case (estado)
            PARADO: begin
                if (p_start && !(modo && tempo == 24'h0))
                    estado_prox = RODANDO;
                else if (p_cont)
                    estado_prox = AJUSTE_H;
            end
            RODANDO: begin
                if (p_start) begin
                    estado_prox = PARADO;
                end else if (tick) begin
                    if (!modo) begin
                        tempo_prox[7:0] = campo_inc(tempo[7:0], LIMITE_MS);
                        if (tempo[7:0] == LIMITE_MS) begin
                            tempo_prox[15:8] = campo_inc(tempo[15:8], LIMITE_MS);
                            if (tempo[15:8] == LIMITE_MS)
                                tempo_prox[23:16] = campo_inc(tempo[23:16], HORA_MAX);
                        end
                    end else begin
                        tempo_prox[7:0] = campo_dec(tempo[7:0], LIMITE_MS);
                        if (tempo[7:0] == 8'h00) begin
                            tempo_prox[15:8] = campo_dec(tempo[15:8], LIMITE_MS);
                            if (tempo[15:8] == 8'h00)
                                tempo_prox[23:16] = campo_dec(tempo[23:16], HORA_MAX);
                        end
                        if (tempo_prox == 24'h0)
                            estado_prox = FIM;
                    end
                end
            end
            AJUSTE_H: begin
                if (ajusta_mais)  tempo_prox[23:16] = campo_inc(tempo[23:16], HORA_MAX);
                if (ajusta_menos) tempo_prox[23:16] = campo_dec(tempo[23:16], HORA_MAX);
                if (p_cont) estado_prox = AJUSTE_M;
            end
            AJUSTE_M: begin
                if (ajusta_mais)  tempo_prox[15:8] = campo_inc(tempo[15:8], LIMITE_MS);
                if (ajusta_menos) tempo_prox[15:8] = campo_dec(tempo[15:8], LIMITE_MS);
                if (p_cont) estado_prox = AJUSTE_S;
            end
            AJUSTE_S: begin
                if (ajusta_mais)  tempo_prox[7:0] = campo_inc(tempo[7:0], LIMITE_MS);
                if (ajusta_menos) tempo_prox[7:0] = campo_dec(tempo[7:0], LIMITE_MS);
                if (p_cont) estado_prox = PARADO;
            end
            FIM: begin
                tempo_prox = 24'h0;
                if (p_start || p_cont) estado_prox = PARADO;
            end
            default: estado_prox = PARADO;
        endcase
    end

    // The prescaler idles at zero outside RODANDO, so every run starts a full period
    always_ff @(posedge clock) begin
        if (reset) begin
            estado   <= PARADO;
            tempo    <= 24'h0;
            segundo  <= 1'b0;
            pre_tick <= '0;
        end else begin
            estado   <= estado_prox;
            tempo    <= tempo_prox;
            segundo  <= tick && !p_start;
            pre_tick <= (estado != RODANDO || tick) ? '0 : pre_tick + PRE_W'(1);
        end
    end

    assign scan_passo = (pre_scan == SCAN_W'(SCAN_DIV - 1));

    always_comb begin
        idx_prox = idx;
        if (scan_passo)
            idx_prox = (idx == DIG_HH) ? DIG_SU : idx + 3'd1;
        digito = tempo[{idx_prox, 2'b00} +: 4];
        ponto  = (idx_prox == DIG_MU) || (idx_prox == DIG_HU)
              || (estado == AJUSTE_H && (idx_prox == DIG_HU || idx_prox == DIG_HH))
              || (estado == AJUSTE_M && (idx_prox == DIG_MU || idx_prox == DIG_MT))
              || (estado == AJUSTE_S && (idx_prox == DIG_SU || idx_prox == DIG_ST));
        an_prox = '1;
        an_prox[idx_prox] = 1'b0;
        cat_prox = bcd_para_seg(digito) & (ponto ? 8'h7F : 8'hFF);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pre_scan <= '0;
            idx      <= DIG_SU;
            an       <= {{(N_AN - 1){1'b1}}, 1'b0};
            dec_cat  <= SEG_0;
        end else begin
            pre_scan <= scan_passo ? '0 : pre_scan + SCAN_W'(1);
            idx      <= idx_prox;
            an       <= an_prox;
            dec_cat  <= cat_prox;
        end
    end

endmodule

// File: tb/tb_relogio_multimodo.sv
// Scenario bench for relogio_multimodo: expected display frames are queued
// as stimulus is applied and compared against the scanned digits.
module tb_relogio_multimodo;

    localparam int TICK_DIV  = 10;
    localparam int SCAN_DIV  = 4;
    localparam int DEB_CYC   = 2;
    localparam int N_AN      = 8;
    localparam int HORAS_MAX = 24;

    localparam logic [3:0] B_START = 4'b1000;
    localparam logic [3:0] B_CONT  = 4'b0100;
    localparam logic [3:0] B_SOMA  = 4'b0010;
    localparam logic [3:0] B_SUB   = 4'b0001;

    localparam logic [7:0] SEG_TAB [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                            8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    logic            clock = 1'b0;
    logic            reset, start, cont, soma, subtracao, modo;
    logic [N_AN-1:0] an;
    logic [7:0]      dec_cat;
    logic            alarme, segundo;

    int          testes = 0;
    int          falhas = 0;
    logic [7:0]  esperado_q[$];
    logic [15:0] scan_q[$];
    logic [7:0]  quadro[6];

    always #5 clock = ~clock;

    relogio_multimodo #(
        .TICK_DIV(TICK_DIV), .SCAN_DIV(SCAN_DIV), .DEB_CYC(DEB_CYC),
        .N_AN(N_AN), .HORAS_MAX(HORAS_MAX)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .cont(cont),
        .soma(soma), .subtracao(subtracao), .modo(modo),
        .an(an), .dec_cat(dec_cat), .alarme(alarme), .segundo(segundo)
    );

    function automatic logic [7:0] seg_esperado(input int d, input bit aceso);
        return aceso ? (SEG_TAB[d] & 8'h7F) : SEG_TAB[d];
    endfunction

    task automatic push_frame(input int h, input int m, input int s, input logic [5:0] pontos);
        int d[6];
        d[0] = s % 10; d[1] = s / 10;
        d[2] = m % 10; d[3] = m / 10;
        d[4] = h % 10; d[5] = h / 10;
        for (int i = 0; i < 6; i++)
            esperado_q.push_back(seg_esperado(d[i], pontos[i]));
    endtask

    task automatic do_reset;
        @(negedge clock);
        reset = 1'b1;
        {start, cont, soma, subtracao} = 4'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Returns at the negedge just after the edge that acts on the press
    task automatic applyStimulus(input logic [3:0] botoes);
        repeat (4) @(negedge clock);
        {start, cont, soma, subtracao} = botoes;
        repeat (6) @(posedge clock);
        @(negedge clock);
        {start, cont, soma, subtracao} = 4'b0;
    endtask

    task automatic capture_frame(input string nome);
        logic [7:0] anterior;
        bit achou;
        anterior = an;
        achou = 1'b0;
        for (int c = 0; c < 60 && !achou; c++) begin
            @(negedge clock);
            if (an == 8'hFE && anterior != 8'hFE) achou = 1'b1;
            anterior = an;
        end
        if (!achou) begin
            testes++;
            falhas++;
            $display("[TB] FAIL %s scan_sync: an never returned to digit 0 (got %h, required fe)", nome, an);
        end
        for (int i = 0; i < 6; i++) begin
            quadro[i] = dec_cat;
            if (i < 5) repeat (SCAN_DIV) @(negedge clock);
        end
    endtask

    task automatic test_reset;
        logic [7:0] m;
        logic [15:0] e;
        reset = 1'b1;
        {start, cont, soma, subtracao} = 4'b0;
        modo = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int c = 0; c < 24; c++) begin
            m = 8'h01 << (c / 4);
            scan_q.push_back({~m, ((c / 4) == 2 || (c / 4) == 4) ? 8'h40 : 8'hC0});
        end
        testes++;
        if (alarme !== 1'b0 || segundo !== 1'b0) begin
            falhas++;
            $display("[TB] FAIL reset_flags: alarme=%b segundo=%b, required 0 0", alarme, segundo);
        end
        for (int c = 0; c < 24; c++) begin
            if (c > 0) @(negedge clock);
            e = scan_q.pop_front();
            testes++;
            if ({an, dec_cat} !== e) begin
                falhas++;
                $display("[TB] FAIL reset_scan cycle %0d: an=%h dec_cat=%h, required an=%h dec_cat=%h",
                         c, an, dec_cat, e[15:8], e[7:0]);
            end
        end
    endtask

    task automatic test_ajuste;
        logic [7:0] e;
        do_reset();
        applyStimulus(B_CONT);
        applyStimulus(B_SUB);
        push_frame(23, 0, 0, 6'b110100);
        capture_frame("ajuste_h");
        for (int i = 0; i < 6; i++) begin
            e = esperado_q.pop_front();
            testes++;
            if (quadro[i] !== e) begin
                falhas++;
                $display("[TB] FAIL ajuste_h digit %0d: got %h, required %h", i, quadro[i], e);
            end
        end
        applyStimulus(B_CONT);
        repeat (3) applyStimulus(B_SOMA);
        applyStimulus(B_CONT);
        applyStimulus(B_CONT);
        push_frame(23, 3, 0, 6'b010100);
        capture_frame("ajuste_fim");
        for (int i = 0; i < 6; i++) begin
            e = esperado_q.pop_front();
            testes++;
            if (quadro[i] !== e) begin
                falhas++;
                $display("[TB] FAIL ajuste_fim digit %0d: got %h, required %h", i, quadro[i], e);
            end
        end
    endtask

    task automatic test_virada;
        logic [7:0] e;
        do_reset();
        modo = 1'b0;
        applyStimulus(B_CONT);
        applyStimulus(B_SUB);
        applyStimulus(B_CONT);
        applyStimulus(B_SUB);
        applyStimulus(B_CONT);
        applyStimulus(B_SUB);
        applyStimulus(B_CONT);
        applyStimulus(B_START);
        repeat (TICK_DIV - 1) @(posedge clock);
        @(negedge clock);
        testes++;
        if (segundo !== 1'b0) begin
            falhas++;
            $display("[TB] FAIL virada_early_tick: segundo=%b, required 0", segundo);
        end
        @(posedge clock);
        @(negedge clock);
        testes++;
        if (segundo !== 1'b1) begin
            falhas++;
            $display("[TB] FAIL virada_tick: segundo=%b, required 1", segundo);
        end
        start = 1'b1;
        @(posedge clock);
        @(negedge clock);
        testes++;
        if (segundo !== 1'b0) begin
            falhas++;
            $display("[TB] FAIL virada_tick_width: segundo=%b, required 0", segundo);
        end
        repeat (5) @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        push_frame(0, 0, 0, 6'b010100);
        capture_frame("virada");
        for (int i = 0; i < 6; i++) begin
            e = esperado_q.pop_front();
            testes++;
            if (quadro[i] !== e) begin
                falhas++;
                $display("[TB] FAIL virada digit %0d: got %h, required %h", i, quadro[i], e);
            end
        end
    endtask

    task automatic test_contagem_regressiva;
        logic [7:0] e;
        do_reset();
        modo = 1'b0;
        applyStimulus(B_CONT);
        applyStimulus(B_CONT);
        applyStimulus(B_CONT);
        applyStimulus(B_SOMA);
        applyStimulus(B_SOMA);
        applyStimulus(B_CONT);
        modo = 1'b1;
        applyStimulus(B_START);
        repeat (TICK_DIV - 1) @(posedge clock);
        @(negedge clock);
        testes++;
        if (segundo !== 1'b0) begin
            falhas++;
            $display("[TB] FAIL regressiva_early_tick: segundo=%b, required 0", segundo);
        end
        @(posedge clock);
        @(negedge clock);
        testes++;
        if (segundo !== 1'b1 || alarme !== 1'b0) begin
            falhas++;
            $display("[TB] FAIL regressiva_tick1: segundo=%b alarme=%b, required 1 0", segundo, alarme);
        end
        repeat (TICK_DIV - 1) @(posedge clock);
        @(negedge clock);
        testes++;
        if (alarme !== 1'b0) begin
            falhas++;
            $display("[TB] FAIL regressiva_early_alarm: alarme=%b, required 0", alarme);
        end
        @(posedge clock);
        @(negedge clock);
        testes++;
        if (alarme !== 1'b1) begin
            falhas++;
            $display("[TB] FAIL regressiva_alarm: alarme=%b, required 1", alarme);
        end
        push_frame(0, 0, 0, 6'b010100);
        capture_frame("fim");
        for (int i = 0; i < 6; i++) begin
            e = esperado_q.pop_front();
            testes++;
            if (quadro[i] !== e) begin
                falhas++;
                $display("[TB] FAIL fim digit %0d: got %h, required %h", i, quadro[i], e);
            end
        end
        testes++;
        if (alarme !== 1'b1) begin
            falhas++;
            $display("[TB] FAIL fim_held: alarme=%b, required 1", alarme);
        end
        applyStimulus(B_CONT);
        testes++;
        if (alarme !== 1'b0) begin
            falhas++;
            $display("[TB] FAIL fim_ack: alarme=%b, required 0", alarme);
        end
        modo = 1'b0;
    endtask

    task automatic test_simultaneo;
        logic [7:0] e;
        do_reset();
        applyStimulus(B_CONT);
        applyStimulus(B_CONT);
        applyStimulus(B_SOMA | B_SUB);
        push_frame(0, 0, 0, 6'b011100);
        capture_frame("simultaneo");
        for (int i = 0; i < 6; i++) begin
            e = esperado_q.pop_front();
            testes++;
            if (quadro[i] !== e) begin
                falhas++;
                $display("[TB] FAIL simultaneo digit %0d: got %h, required %h", i, quadro[i], e);
            end
        end
        applyStimulus(B_SUB);
        applyStimulus(B_START);
        push_frame(0, 59, 0, 6'b011100);
        capture_frame("ajuste_m_start");
        for (int i = 0; i < 6; i++) begin
            e = esperado_q.pop_front();
            testes++;
            if (quadro[i] !== e) begin
                falhas++;
                $display("[TB] FAIL ajuste_m_start digit %0d: got %h, required %h", i, quadro[i], e);
            end
        end
    endtask

    task automatic test_reset_meio;
        logic [7:0] e;
        int pulsos;
        do_reset();
        modo = 1'b0;
        applyStimulus(B_START);
        // The reset edge lands exactly where the eighth tick would have been
        repeat (8 * TICK_DIV - 1) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        testes++;
        if (segundo !== 1'b0 || alarme !== 1'b0 || an !== 8'hFE || dec_cat !== 8'hC0) begin
            falhas++;
            $display("[TB] FAIL reset_meio_outputs: segundo=%b alarme=%b an=%h dec_cat=%h, required 0 0 fe c0",
                     segundo, alarme, an, dec_cat);
        end
        reset = 1'b0;
        pulsos = 0;
        repeat (30) begin
            @(negedge clock);
            if (segundo) pulsos++;
        end
        testes++;
        if (pulsos !== 0) begin
            falhas++;
            $display("[TB] FAIL reset_meio_stopped: %0d segundo pulses, required 0", pulsos);
        end
        push_frame(0, 0, 0, 6'b010100);
        capture_frame("reset_meio");
        for (int i = 0; i < 6; i++) begin
            e = esperado_q.pop_front();
            testes++;
            if (quadro[i] !== e) begin
                falhas++;
                $display("[TB] FAIL reset_meio digit %0d: got %h, required %h", i, quadro[i], e);
            end
        end
        modo = 1'b1;
        applyStimulus(B_START);
        pulsos = 0;
        repeat (3 * TICK_DIV) begin
            @(negedge clock);
            if (segundo) pulsos++;
        end
        testes++;
        if (pulsos !== 0 || alarme !== 1'b0) begin
            falhas++;
            $display("[TB] FAIL timer_zero_start: %0d pulses alarme=%b, required 0 0", pulsos, alarme);
        end
        push_frame(0, 0, 0, 6'b010100);
        capture_frame("timer_zero_start");
        for (int i = 0; i < 6; i++) begin
            e = esperado_q.pop_front();
            testes++;
            if (quadro[i] !== e) begin
                falhas++;
                $display("[TB] FAIL timer_zero_start digit %0d: got %h, required %h", i, quadro[i], e);
            end
        end
        modo = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ajuste();
        test_virada();
        test_contagem_regressiva();
        test_simultaneo();
        test_reset_meio();
        $display("[TB] %0d tests run, %0d failed", testes, falhas);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

endmodule
